// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding and constants for the line memory controller
package dmem_pkg;

    // Controller states: accept in IDLE, count down in BUSY, one-cycle ack in ACK.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Byte offset bits inside a 256-bit (32-byte) line.
    localparam int LINE_OFFSET_W   = 5;
    localparam int DEFAULT_LATENCY = 10;

endpackage

// File: rtl/dmem_line_array.sv
// rtl/dmem_line_array.sv - DEPTH x LINE_W line storage, one write port and one registered read port
//
// Ports:
//   i_clk      clock
//   i_rst_n    asynchronous active-low reset (clears the read register only)
//   i_wr_en    write i_wr_data into line i_idx at this edge
//   i_rd_en    capture line i_idx into o_rd_data at this edge
//   i_idx      line index
//   i_wr_data  line to write
//   o_rd_data  registered read line, held until the next read
module dmem_line_array #(
    parameter int LINE_W = 256,
    parameter int DEPTH  = 512,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic              i_rd_en,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [LINE_W-1:0] i_wr_data,
    output logic [LINE_W-1:0] o_rd_data
);

    logic [LINE_W-1:0] r_mem [DEPTH];
    logic [LINE_W-1:0] r_rd_data;

    // Storage is deliberately not reset; contents survive a controller reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_idx] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_idx];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dmem_line_ctrl.sv
// rtl/dmem_line_ctrl.sv - line-granular data memory with fixed access latency and one-cycle ack
//
// Serves one 256-bit line read or write at a time behind the L1 data cache.
// A request accepted at edge E0 in IDLE raises ack_o at edge E0+LATENCY for one cycle.
//
// Ports:
//   clk_i     clock
//   rst_i     asynchronous active-low reset
//   enable_i  request valid (only looked at in IDLE)
//   write_i   1 = line write, 0 = line read
//   addr_i    byte address; line index = addr_i[5 +: log2(DEPTH)]
//   data_i    write line, sampled at acceptance
//   data_o    read line, valid in the ack cycle of a read and held until the next read
//   ack_o     one-cycle completion pulse
//   rd_cnt_o  saturating count of completed reads   (only with DMEM_STATS_EN)
//   wr_cnt_o  saturating count of completed writes  (only with DMEM_STATS_EN)
//
// Build option: define DMEM_STATS_EN to add the read/write completion counters.
module dmem_line_ctrl
    import dmem_pkg::*;
#(
    parameter int LINE_W  = 256,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 512,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic [LINE_W-1:0] data_o,
`ifdef DMEM_STATS_EN
    output logic [31:0]       rd_cnt_o,
    output logic [31:0]       wr_cnt_o,
`endif
    output logic              ack_o
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_count;
    logic [7:0]        w_count_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_write;
    logic [LINE_W-1:0] r_data;
    logic              w_accept;
    logic              w_enter_ack;
    logic              w_unused_addr;

    // Offset bits and bits above the index are don't-care; high bits alias.
    assign w_unused_addr = ^{addr_i[LINE_OFFSET_W-1:0], addr_i[ADDR_W-1:LINE_OFFSET_W+IDX_W]};

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_accept    = 1'b0;
        w_enter_ack = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable_i) begin
                    w_accept    = 1'b1;
                    w_count_nxt = 8'(LATENCY - 1);
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (r_count == 8'd0) begin
                    w_enter_ack = 1'b1;
                    w_state_nxt = ACK;
                end else begin
                    w_count_nxt = r_count - 8'd1;
                end
            end
            // ACK always returns to IDLE, so a still-asserted request needs a fresh IDLE edge.
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_count <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Request is frozen at acceptance; later input changes cannot disturb it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_idx   <= '0;
            r_write <= 1'b0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_idx   <= addr_i[LINE_OFFSET_W +: IDX_W];
            r_write <= write_i;
            r_data  <= data_i;
        end
    end

    // Array access happens on the edge entering ACK; a reset before then aborts it.
    dmem_line_array #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .i_clk     (clk_i),
        .i_rst_n   (rst_i),
        .i_wr_en   (w_enter_ack & r_write),
        .i_rd_en   (w_enter_ack & ~r_write),
        .i_idx     (r_idx),
        .i_wr_data (r_data),
        .o_rd_data (data_o)
    );

    // Decoded from the state register so an async reset drops it immediately.
    assign ack_o = (r_state == ACK);

`ifdef DMEM_STATS_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rd_cnt <= 32'd0;
            r_wr_cnt <= 32'd0;
        end else if (r_state == ACK) begin
            if (!r_write && r_rd_cnt != 32'hFFFF_FFFF) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if (r_write && r_wr_cnt != 32'hFFFF_FFFF) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
        end
    end

    assign rd_cnt_o = r_rd_cnt;
    assign wr_cnt_o = r_wr_cnt;
`else
    // No statistics state in this build.
`endif

endmodule
